// File: rtl/oled_frame_streamer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oled_frame_streamer_if : pixel-source raster and SSD1331 SPI pin bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface oled_frame_streamer_if #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic          frame_begin;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [15:0]   pixel_data;
  logic          spi_cs_n;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_dc;

  modport master (
    input  start, pixel_data,
    output busy, done, frame_begin, x, y,
    output spi_cs_n, spi_sclk, spi_mosi, spi_dc
  );

  modport slave (
    output start, pixel_data,
    input  busy, done, frame_begin, x, y,
    input  spi_cs_n, spi_sclk, spi_mosi, spi_dc
  );
endinterface
`default_nettype wire

// File: rtl/oled_frame_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oled_frame_streamer : raster scan + SSD1331 4-wire SPI frame serialiser
// Rev 1.0
// ---------------------------------------------------------------------------
module oled_frame_streamer #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64,
  parameter int CLK_DIV     = 4,
  parameter int SRC_LATENCY = 1
) (
  input logic                   clk,
  input logic                   reset,
  oled_frame_streamer_if.master bus
);
  localparam int XW      = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CNT_TOP = (CLK_DIV - 1 > SRC_LATENCY) ? CLK_DIV - 1 : SRC_LATENCY;
  localparam int CW      = (CNT_TOP > 0) ? $clog2(CNT_TOP + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          phase;
  logic [3:0]    bit_cnt;
  logic [2:0]    byte_cnt;
  logic [15:0]   sreg;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic       half_end, bit_end, last_bit, unit_end, last_byte;
  logic       fetch_end, last_col, last_row;
  logic [7:0] next_cmd;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h15;
      3'd2:    cmd_byte = 8'(WIDTH - 1);
      3'd3:    cmd_byte = 8'h75;
      3'd5:    cmd_byte = 8'(HEIGHT - 1);
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  assign half_end  = (cnt == CW'(CLK_DIV - 1));
  assign bit_end   = half_end && phase;
  assign last_bit  = (state == S_CMD) ? (bit_cnt == 4'd7) : (bit_cnt == 4'd15);
  assign unit_end  = bit_end && last_bit;
  assign last_byte = (byte_cnt == 3'd5);
  assign fetch_end = (cnt == CW'(SRC_LATENCY));
  assign last_col  = (x_q == XW'(WIDTH - 1));
  assign last_row  = (y_q == YW'(HEIGHT - 1));
  assign next_cmd  = cmd_byte(byte_cnt + 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_CMD;
      S_CMD:    if (unit_end && last_byte) state_nxt = S_FETCH;
      S_FETCH:  if (fetch_end) state_nxt = S_SHIFT;
      S_SHIFT:  if (unit_end) state_nxt = (last_col && last_row) ? S_FINISH : S_FETCH;
      S_FINISH: if (half_end) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bit-timing counters, shift register and raster position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sreg     <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt      <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sreg     <= {cmd_byte(3'd0), 8'h00};
          end
        end
        S_CMD, S_SHIFT: begin
          cnt <= half_end ? '0 : cnt + CW'(1);
          if (half_end) phase <= ~phase;
          if (bit_end) begin
            if (!last_bit) begin
              sreg    <= {sreg[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              bit_cnt <= '0;
              if (state == S_CMD) begin
                if (!last_byte) begin
                  byte_cnt <= byte_cnt + 3'd1;
                  sreg     <= {next_cmd, 8'h00};
                end
              end else if (!last_col) begin
                x_q <= x_q + XW'(1);
              end else if (!last_row) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end
            end
          end
        end
        S_FETCH: begin
          if (fetch_end) begin
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            sreg    <= bus.pixel_data;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FINISH: begin
          if (half_end) begin
            cnt <= '0;
            x_q <= '0;
            y_q <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // SCLK only toggles while shifting; it idles high in every other state.
  always_comb begin
    bus.busy        = (state == S_CMD) || (state == S_FETCH) ||
                      (state == S_SHIFT) || (state == S_FINISH);
    bus.done        = (state == S_DONE);
    bus.frame_begin = (state == S_FETCH) || (state == S_SHIFT);
    bus.spi_cs_n    = !bus.busy;
    bus.spi_sclk    = ((state == S_CMD) || (state == S_SHIFT)) ? phase : 1'b1;
    bus.spi_mosi    = (state == S_IDLE) ? 1'b0 : sreg[15];
    bus.spi_dc      = (state == S_FETCH) || (state == S_SHIFT) || (state == S_FINISH);
    bus.x           = x_q;
    bus.y           = y_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_oled_frame_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_oled_frame_streamer : SPI-decoding bench for two streamer configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_oled_frame_streamer;
  localparam int W_A = 4, H_A = 2, CD_A = 1, L_A = 1;
  localparam int W_B = 3, H_B = 2, CD_B = 2, L_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rnd_mode = 1'b1;
  logic [15:0] rnd_val = 16'h0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  oled_frame_streamer_if #(.WIDTH(W_A), .HEIGHT(H_A)) bus_a ();
  oled_frame_streamer_if #(.WIDTH(W_B), .HEIGHT(H_B)) bus_b ();

  oled_frame_streamer #(.WIDTH(W_A), .HEIGHT(H_A), .CLK_DIV(CD_A), .SRC_LATENCY(L_A))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  oled_frame_streamer #(.WIDTH(W_B), .HEIGHT(H_B), .CLK_DIV(CD_B), .SRC_LATENCY(L_B))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  function automatic logic [15:0] src(input int x, input int y);
    logic [1:0] xb;
    logic       yb;
    xb = x[1:0];
    yb = y[0];
    return {xb, yb, 13'h1ABC};
  endfunction

  // Pixel sources: value appears exactly SrcLatency cycles after x/y change.
  logic [15:0] pipe_a [0:L_A-1];
  logic [15:0] pipe_b [0:L_B-1];
  always @(posedge clk) begin
    pipe_a[0] <= src(int'(bus_a.x), int'(bus_a.y));
    for (int i = 1; i < L_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  always @(posedge clk) begin
    pipe_b[0] <= src(int'(bus_b.x), int'(bus_b.y));
    for (int i = 1; i < L_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign bus_a.pixel_data = rnd_mode ? rnd_val : pipe_a[L_A-1];
  assign bus_b.pixel_data = rnd_mode ? ~rnd_val : pipe_b[L_B-1];

  logic [1:0] sclk_s, mosi_s, cs_s, dc_s, busy_s, done_s, fb_s;
  assign sclk_s = {bus_b.spi_sclk, bus_a.spi_sclk};
  assign mosi_s = {bus_b.spi_mosi, bus_a.spi_mosi};
  assign cs_s   = {bus_b.spi_cs_n, bus_a.spi_cs_n};
  assign dc_s   = {bus_b.spi_dc,   bus_a.spi_dc};
  assign busy_s = {bus_b.busy,     bus_a.busy};
  assign done_s = {bus_b.done,     bus_a.done};
  assign fb_s   = {bus_b.frame_begin, bus_a.frame_begin};

  function automatic int cfg_w(input int d);  return (d == 0) ? W_A  : W_B;  endfunction
  function automatic int cfg_h(input int d);  return (d == 0) ? H_A  : H_B;  endfunction
  function automatic int cfg_cd(input int d); return (d == 0) ? CD_A : CD_B; endfunction
  function automatic int cfg_l(input int d);  return (d == 0) ? L_A  : L_B;  endfunction

  // Expected stream item i: six window bytes, then pixels in x-fastest raster order.
  function automatic logic [15:0] exp_item(input int d, input int i);
    int p;
    case (i)
      0: return 16'h0015;
      1: return 16'h0000;
      2: return 16'(cfg_w(d) - 1);
      3: return 16'h0075;
      4: return 16'h0000;
      5: return 16'(cfg_h(d) - 1);
      default: begin
        p = i - 6;
        return src(p % cfg_w(d), p / cfg_w(d));
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int idx [2], nbit [2], hi_run [2], lo_run [2], frames [2];
  logic [15:0] acc [2];
  logic [15:0] rx [2][0:15];
  logic [1:0] prev_sclk;

  // Decoder / compare process: rebuilds bytes and pixels from the pins.
  initial begin
    int total, len, exp_hi;
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; nbit[d] = 0; hi_run[d] = 0; lo_run[d] = 0; frames[d] = 0; acc[d] = '0;
    end
    prev_sclk = 2'b11;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total = 6 + cfg_w(d) * cfg_h(d);
        check($sformatf("invariant%0d", d),
              {28'd0, cs_s[d] == !busy_s[d], cs_s[d] ? sclk_s[d] : 1'b1,
               done_s[d] ? !fb_s[d] : 1'b1, busy_s[d] ? 1'b1 : !fb_s[d]}, 32'hF);
        if (!reset) begin
          idx[d] = 0; nbit[d] = 0; hi_run[d] = 0; lo_run[d] = 0;
        end else begin
          if (!cs_s[d] && !prev_sclk[d] && sclk_s[d]) begin
            check($sformatf("sclk_low%0d", d), lo_run[d], cfg_cd(d));
            check($sformatf("dc%0d_item%0d", d, idx[d]), dc_s[d], idx[d] >= 6);
            if (idx[d] >= total) check($sformatf("overrun%0d", d), 1, 0);
            acc[d] = {acc[d][14:0], mosi_s[d]};
            nbit[d]++;
            len = (idx[d] < 6) ? 8 : 16;
            if (nbit[d] == len && idx[d] < total) begin
              if (len == 8) acc[d] = {8'h00, acc[d][7:0]};
              check($sformatf("item%0d_%0d", d, idx[d]), acc[d], exp_item(d, idx[d]));
              rx[d][idx[d]] = acc[d];
              idx[d]++;
              nbit[d] = 0;
            end
          end
          if (!cs_s[d] && prev_sclk[d] && !sclk_s[d]) begin
            if (idx[d] == 0 && nbit[d] == 0) exp_hi = 0;
            else exp_hi = cfg_cd(d) + ((nbit[d] == 0 && idx[d] >= 6) ? cfg_l(d) + 1 : 0);
            check($sformatf("sclk_high%0d_item%0d", d, idx[d]), hi_run[d], exp_hi);
          end
          if (done_s[d]) begin
            check($sformatf("frame_len%0d", d), idx[d], total);
            frames[d]++;
            idx[d] = 0;
            nbit[d] = 0;
          end
          hi_run[d] = (!cs_s[d] && sclk_s[d])  ? hi_run[d] + 1 : 0;
          lo_run[d] = (!cs_s[d] && !sclk_s[d]) ? lo_run[d] + 1 : 0;
        end
        prev_sclk[d] = sclk_s[d];
      end
    end
  end

  task automatic set_start(input int d, input logic v);
    if (d == 0) bus_a.start = v;
    else        bus_b.start = v;
  endtask

  task automatic pulse_start(input int d);
    set_start(d, 1'b1);
    @(posedge clk); #1;
    set_start(d, 1'b0);
  endtask

  task automatic wait_done(input int d, input int budget, input bit start_on_done);
    int n;
    n = 0;
    while (done_s[d] !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_s[d] !== 1'b1) begin
      check($sformatf("done_timeout%0d", d), done_s[d], 1);
    end else if (start_on_done) begin
      pulse_start(d);
    end
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;

    // Idle with random pixel data and no start: everything stays at reset values.
    for (int i = 0; i < 100; i++) begin
      rnd_val = 16'($urandom);
      @(posedge clk); #1;
      check("idle_ctl_a", {busy_s[0], done_s[0], fb_s[0], cs_s[0], sclk_s[0], mosi_s[0], dc_s[0]}, 7'b0001100);
      check("idle_ctl_b", {busy_s[1], done_s[1], fb_s[1], cs_s[1], sclk_s[1], mosi_s[1], dc_s[1]}, 7'b0001100);
      check("idle_xy", {bus_a.x, bus_a.y, bus_b.x, bus_b.y}, 6'd0);
    end
    rnd_mode = 1'b0;

    // Frame 1 with a mid-frame start and a start on the done cycle.
    pulse_start(0);
    check("busy_after_start", busy_s[0], 1);
    check("cs_after_start", cs_s[0], 0);
    repeat (50) @(posedge clk);
    #1 pulse_start(0);
    wait_done(0, 2000, 1);
    repeat (20) @(posedge clk);
    #1;
    check("frames_after_reject", frames[0], 1);
    check("busy_after_reject", busy_s[0], 0);
    check("cs_after_frame", cs_s[0], 1);
    check("rx_a_byte2", rx[0][2], 16'h0003);
    check("rx_a_byte5", rx[0][5], 16'h0001);
    check("rx_a_px1", rx[0][7], 16'h5ABC);
    check("rx_a_px7", rx[0][13], 16'hFABC);

    // Frame 2, then a start one cycle after its done launches frame 3.
    pulse_start(0);
    wait_done(0, 2000, 0);
    @(posedge clk); #1;
    pulse_start(0);
    check("relaunch_busy", busy_s[0], 1);
    wait_done(0, 2000, 0);
    repeat (2) @(posedge clk);
    #1;
    check("frames_after_relaunch", frames[0], 3);

    // Longer source latency and slower SCLK on the second instance.
    pulse_start(1);
    wait_done(1, 4000, 0);
    repeat (2) @(posedge clk);
    #1;
    check("frames_b", frames[1], 1);
    check("rx_b_byte2", rx[1][2], 16'h0002);
    check("rx_b_px5", rx[1][11], 16'hBABC);

    // Reset in the middle of pixel 3, bit 7.
    pulse_start(0);
    begin
      int n;
      n = 0;
      while (!(idx[0] == 9 && nbit[0] == 7) && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      check("reach_pixel3_bit7", {idx[0] == 9, nbit[0] == 7}, 2'b11);
    end
    reset = 1'b0;
    #1;
    check("abort_ctl_a", {busy_s[0], done_s[0], fb_s[0], cs_s[0], sclk_s[0], mosi_s[0], dc_s[0]}, 7'b0001100);
    check("abort_xy_a", {bus_a.x, bus_a.y}, 3'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    pulse_start(0);
    wait_done(0, 2000, 0);
    repeat (2) @(posedge clk);
    #1;
    check("frames_after_abort", frames[0], 4);
    check("rx_a_first_after_abort", rx[0][0], 16'h0015);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
